// File: rtl/panel_pkg.sv
// Shared constants for the front-panel key path and the SPI slave that reads it.
// READ_PORT_CMD lives here so the key map and the SPI command decoder cannot drift apart.
package panel_pkg;

    localparam int KEY_WIDTH            = 8;
    localparam int DEBOUNCE_CNT_DEFAULT = 16;
    localparam int CNT_W_DEFAULT        = 5;

    localparam logic [7:0] READ_PORT_CMD = 8'h1F;

    typedef logic [KEY_WIDTH-1:0] key_vec_t;

endpackage

// File: rtl/key_debounce.sv
// One key line: two-flop synchroniser, stable-mismatch counter and accepted level.
// press pulses high on the same cycle key_state_d goes 0->1, so the parent can latch it on that edge.
module key_debounce
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic SCLK,
    input  logic NRST,
    input  logic key_raw_n,
    output logic key_state,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    if (DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > (1 << CNT_W) - 1) begin : g_bad_cnt
        $error("key_debounce: DEBOUNCE_CNT out of range for CNT_W");
    end

    // Sync flops carry raw (active-low) polarity so that reset value 1 means released.
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level;

    always_comb begin
        s1_d    = key_raw_n;
        s2_d    = s1_q;
        level   = ~s2_q;
        state_d = state_q;
        cnt_d   = '0;
        press   = 1'b0;
        if (level != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = level;
                press   = level;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge SCLK or posedge NRST) begin
        if (NRST) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_state = state_q;

endmodule

// File: rtl/panel_key_latch.sv
// Front-panel key conditioner: per-key debounce, sticky press events with masked clear, and IRQ.
// A press accepted on the same edge as a clear of that bit wins, so no press is ever lost.
module panel_key_latch
    import panel_pkg::*;
#(
    parameter int WIDTH        = KEY_WIDTH,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic             SCLK,
    input  logic             NRST,
    input  logic [WIDTH-1:0] KEYS_RAW,
    input  logic             CLR_STB,
    input  logic [WIDTH-1:0] CLR_MASK,
    output logic [WIDTH-1:0] KEY_STATE,
    output logic [WIDTH-1:0] KEY_EVENT,
    output logic             IRQ
);

    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] key_event_q, key_event_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .CNT_W        (CNT_W)
        ) u_key_debounce (
            .SCLK      (SCLK),
            .NRST      (NRST),
            .key_raw_n (KEYS_RAW[i]),
            .key_state (KEY_STATE[i]),
            .press     (press[i])
        );
    end

    always_comb begin
        clr         = CLR_STB ? CLR_MASK : '0;
        key_event_d = (key_event_q & ~clr) | press;
    end

    always_ff @(posedge SCLK or posedge NRST) begin
        if (NRST) begin
            key_event_q <= '0;
        end else begin
            key_event_q <= key_event_d;
        end
    end

    assign KEY_EVENT = key_event_q;
    assign IRQ       = |key_event_q;

endmodule

// File: tb/tb_panel_key_latch.sv
// Directed bench for panel_key_latch with DEBOUNCE_CNT=4: expected values are hand-derived
// from the 2-flop sync + 4-cycle debounce timing (state changes on the 6th edge after a raw change).
module tb_panel_key_latch;

    logic       SCLK;
    logic       NRST;
    logic [7:0] KEYS_RAW;
    logic       CLR_STB;
    logic [7:0] CLR_MASK;
    logic [7:0] KEY_STATE;
    logic [7:0] KEY_EVENT;
    logic       IRQ;

    int errors = 0;
    int checks = 0;

    panel_key_latch #(
        .WIDTH        (8),
        .DEBOUNCE_CNT (4),
        .CNT_W        (5)
    ) dut (
        .SCLK      (SCLK),
        .NRST      (NRST),
        .KEYS_RAW  (KEYS_RAW),
        .CLR_STB   (CLR_STB),
        .CLR_MASK  (CLR_MASK),
        .KEY_STATE (KEY_STATE),
        .KEY_EVENT (KEY_EVENT),
        .IRQ       (IRQ)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge SCLK);
            #1;
        end
    endtask

    task automatic test_reset;
        NRST     = 1'b1;
        KEYS_RAW = 8'hFF;
        CLR_STB  = 1'b0;
        CLR_MASK = 8'h00;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            checks++;
            if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h00 || IRQ !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: state=%h event=%h irq=%b required 00 00 0",
                         c, KEY_STATE, KEY_EVENT, IRQ);
            end
        end
        NRST = 1'b0;
        tick(4);
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h00 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL idle: state=%h event=%h irq=%b required 00 00 0",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
    endtask

    task automatic test_clean_press;
        KEYS_RAW = 8'hFE;
        tick(5);
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h00 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL press_edge5: state=%h event=%h irq=%b required 00 00 0",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
        tick(1);
        checks++;
        if (KEY_STATE !== 8'h01 || KEY_EVENT !== 8'h01 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL press_edge6: state=%h event=%h irq=%b required 01 01 1",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
    endtask

    task automatic test_release_clear;
        KEYS_RAW = 8'hFF;
        tick(5);
        checks++;
        if (KEY_STATE !== 8'h01) begin
            errors++;
            $display("FAIL release_edge5: state=%h required 01", KEY_STATE);
        end
        tick(1);
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h01 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL release_edge6: state=%h event=%h irq=%b required 00 01 1",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
        CLR_STB  = 1'b1;
        CLR_MASK = 8'h01;
        tick(1);
        CLR_STB  = 1'b0;
        CLR_MASK = 8'h00;
        checks++;
        if (KEY_EVENT !== 8'h00 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL clear_bit0: event=%h irq=%b required 00 0", KEY_EVENT, IRQ);
        end
    endtask

    task automatic test_glitch;
        KEYS_RAW = 8'hF7;
        tick(3);
        KEYS_RAW = 8'hFF;
        tick(10);
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h00 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL glitch3: state=%h event=%h irq=%b required 00 00 0",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
    endtask

    task automatic test_chatter;
        KEYS_RAW = 8'hF7;
        tick(3);
        KEYS_RAW = 8'hFF;
        tick(1);
        KEYS_RAW = 8'hF7;
        tick(5);
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h00) begin
            errors++;
            $display("FAIL chatter_edge9: state=%h event=%h required 00 00", KEY_STATE, KEY_EVENT);
        end
        tick(1);
        checks++;
        if (KEY_STATE !== 8'h08 || KEY_EVENT !== 8'h08 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL chatter_edge10: state=%h event=%h irq=%b required 08 08 1",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
        KEYS_RAW = 8'hFF;
        tick(8);
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h08) begin
            errors++;
            $display("FAIL chatter_release: state=%h event=%h required 00 08", KEY_STATE, KEY_EVENT);
        end
    endtask

    task automatic test_collision;
        KEYS_RAW = 8'h7F;
        tick(5);
        CLR_STB  = 1'b1;
        CLR_MASK = 8'hFF;
        tick(1);
        CLR_STB  = 1'b0;
        CLR_MASK = 8'h00;
        checks++;
        if (KEY_STATE !== 8'h80 || KEY_EVENT !== 8'h80 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL collision: state=%h event=%h irq=%b required 80 80 1",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
        CLR_STB  = 1'b1;
        CLR_MASK = 8'h00;
        tick(1);
        CLR_STB  = 1'b0;
        checks++;
        if (KEY_EVENT !== 8'h80 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL clear_mask0: event=%h irq=%b required 80 1", KEY_EVENT, IRQ);
        end
        KEYS_RAW = 8'hFF;
        tick(8);
        CLR_STB  = 1'b1;
        CLR_MASK = 8'hFF;
        tick(1);
        CLR_STB  = 1'b0;
        CLR_MASK = 8'h00;
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h00 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL clear_all: state=%h event=%h irq=%b required 00 00 0",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
    endtask

    task automatic test_multi_key;
        KEYS_RAW = 8'h5A;
        tick(5);
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h00) begin
            errors++;
            $display("FAIL multi_edge5: state=%h event=%h required 00 00", KEY_STATE, KEY_EVENT);
        end
        tick(1);
        checks++;
        if (KEY_STATE !== 8'hA5 || KEY_EVENT !== 8'hA5 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL multi_edge6: state=%h event=%h irq=%b required A5 A5 1",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
        CLR_STB  = 1'b1;
        CLR_MASK = 8'h05;
        tick(1);
        CLR_STB  = 1'b0;
        CLR_MASK = 8'h00;
        checks++;
        if (KEY_STATE !== 8'hA5 || KEY_EVENT !== 8'hA0 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL partial_clear: state=%h event=%h irq=%b required A5 A0 1",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
    endtask

    task automatic test_async_reset;
        // Keys stay held (0x5A); reset lands between edges and must act at once.
        #3;
        NRST = 1'b1;
        #1;
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h00 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%h event=%h irq=%b required 00 00 0",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
        tick(2);
        NRST = 1'b0;
        tick(5);
        checks++;
        if (KEY_STATE !== 8'h00 || KEY_EVENT !== 8'h00) begin
            errors++;
            $display("FAIL repress_edge5: state=%h event=%h required 00 00", KEY_STATE, KEY_EVENT);
        end
        tick(1);
        checks++;
        if (KEY_STATE !== 8'hA5 || KEY_EVENT !== 8'hA5 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL repress_edge6: state=%h event=%h irq=%b required A5 A5 1",
                     KEY_STATE, KEY_EVENT, IRQ);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_clear();
        test_glitch();
        test_chatter();
        test_collision();
        test_multi_key();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
